// File: rtl/cp0_pkg.sv
// Shared constants and types for the CP0 exception/interrupt controller.
package cp0_pkg;
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] CP0_VECTOR = 32'h0000_4180;

    typedef enum logic {
        MODE_NORMAL  = 1'b0,
        MODE_HANDLER = 1'b1
    } mode_e;

    // A delay-slot victim restarts at its branch, one word earlier.
    function automatic logic [31:0] victim_pc(input logic [31:0] pc, input logic bd);
        logic [31:0] v;
        v = bd ? pc - 32'd4 : pc;
        return {v[31:2], 2'b00};
    endfunction
endpackage

// File: rtl/cp0_ctrl_if.sv
// Pipeline-side bus of the CP0 controller: mfc0/mtc0, M-stage exception info, flush request.
interface cp0_ctrl_if;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        we;
    logic [31:0] pc_m;
    logic        bd_m;
    logic [4:0]  exc_code_m;
    logic        eret_m;
    logic [5:0]  hw_int;
    logic [31:0] rd_data;
    logic [31:0] epc;
    logic        req;
    logic [31:0] handler_pc;

    modport master (
        output rd_addr, wr_addr, wr_data, we, pc_m, bd_m, exc_code_m, eret_m, hw_int,
        input  rd_data, epc, req, handler_pc
    );

    modport slave (
        input  rd_addr, wr_addr, wr_data, we, pc_m, bd_m, exc_code_m, eret_m, hw_int,
        output rd_data, epc, req, handler_pc
    );
endinterface

// File: rtl/cp0_int_arb.sv
// Combinational request arbitration: masked interrupts beat synchronous exceptions.
module cp0_int_arb
    import cp0_pkg::*;
(
    input  logic [5:0] hw_int,
    input  logic [5:0] im,
    input  logic       ie,
    input  logic       exl,
    input  logic [4:0] exc_code_m,
    output logic       req,
    output logic [4:0] exc_code
);
    logic int_pend;
    logic exc_pend;

    always_comb begin
        int_pend = (|(hw_int & im)) & ie & ~exl;
        exc_pend = (exc_code_m != EXC_INT) & ~exl;
        req      = int_pend | exc_pend;
        exc_code = int_pend ? EXC_INT : exc_code_m;
    end
endmodule

// File: rtl/cp0_ctrl.sv
// CP0 register file (SR/Cause/EPC/PrID) and NORMAL/HANDLER mode for the M-stage flush request.
module cp0_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h2020_0701,
    parameter logic [31:0] HANDLER_PC = CP0_VECTOR
) (
    input  logic       clk,
    input  logic       reset,
    cp0_ctrl_if.slave  bus
);
    mode_e       mode_q, mode_d;
    logic        exl;
    logic [5:0]  sr_im_q;
    logic        sr_ie_q;
    logic        cause_bd_q;
    logic [5:0]  cause_ip_q;
    logic [4:0]  cause_exc_q;
    logic [31:0] epc_q;
    logic        req;
    logic [4:0]  exc_sel;
    logic        wr_sr;
    logic        wr_epc;

    cp0_int_arb u_arb (
        .hw_int     (bus.hw_int),
        .im         (sr_im_q),
        .ie         (sr_ie_q),
        .exl        (exl),
        .exc_code_m (bus.exc_code_m),
        .req        (req),
        .exc_code   (exc_sel)
    );

    // An entry in the same cycle swallows the mtc0.
    assign wr_sr  = bus.we & (bus.wr_addr == CP0_SR)  & ~req;
    assign wr_epc = bus.we & (bus.wr_addr == CP0_EPC) & ~req;

    always_ff @(posedge clk) begin
        if (!reset) mode_q <= MODE_NORMAL;
        else        mode_q <= mode_d;
    end

    // eret outranks an mtc0 to SR for the EXL bit only.
    always_comb begin
        mode_d = mode_q;
        if (req)              mode_d = MODE_HANDLER;
        else if (bus.eret_m)  mode_d = MODE_NORMAL;
        else if (wr_sr)       mode_d = bus.wr_data[1] ? MODE_HANDLER : MODE_NORMAL;
    end

    always_comb begin
        exl = (mode_q == MODE_HANDLER);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sr_im_q     <= '0;
            sr_ie_q     <= 1'b0;
            cause_bd_q  <= 1'b0;
            cause_ip_q  <= '0;
            cause_exc_q <= '0;
            epc_q       <= '0;
        end else begin
            cause_ip_q <= bus.hw_int;
            if (req) begin
                cause_bd_q  <= bus.bd_m;
                cause_exc_q <= exc_sel;
                epc_q       <= victim_pc(bus.pc_m, bus.bd_m);
            end else begin
                if (wr_sr) begin
                    sr_im_q <= bus.wr_data[15:10];
                    sr_ie_q <= bus.wr_data[0];
                end
                if (wr_epc) epc_q <= {bus.wr_data[31:2], 2'b00};
            end
        end
    end

    always_comb begin
        case (bus.rd_addr)
            CP0_SR:    bus.rd_data = {16'h0000, sr_im_q, 8'h00, exl, sr_ie_q};
            CP0_CAUSE: bus.rd_data = {cause_bd_q, 15'h0000, cause_ip_q, 3'b000, cause_exc_q, 2'b00};
            CP0_EPC:   bus.rd_data = epc_q;
            CP0_PRID:  bus.rd_data = PRID_VAL;
            default:   bus.rd_data = 32'h0000_0000;
        endcase
    end

    assign bus.epc        = epc_q;
    assign bus.req        = req;
    assign bus.handler_pc = HANDLER_PC;
endmodule
